// File: rtl/ecp3_csa_seq.sv
// ecp3_csa_seq: bring-up and supervision sequencer for the ECP3 clock-sync/
// alignment block. It waits for a stable lock, pulses the datapath reset,
// waits for alignment to settle and retries on error or timeout. It then
// reports ready/fail to the DDR controller and gates DQS DLL update freezes.

module ecp3_csa_seq #(
   parameter int LOCK_CYCLES   = 64,
   parameter int RST_CYCLES    = 8,
   parameter int ALIGN_TIMEOUT = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int MAX_RETRY     = 3
) (
   input  logic       sclk,
   input  logic       reset_n,
   input  logic       all_lock,
   input  logic       good,
   input  logic       err,
   input  logic       dll_hold_req,
   output logic       dll_hold_ack,
   output logic       uddcntln,
   output logic       reset_datapath,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt
);

   localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);
   localparam int RST_W    = $clog2(RST_CYCLES + 1);
   localparam int TMO_W    = $clog2(ALIGN_TIMEOUT + 1);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYCLES - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(ALIGN_TIMEOUT - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0]          RETRY_MAX   = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      WAIT_LOCK,
      DP_RST,
      ALIGN,
      RETRY,
      READY,
      FAIL
   } state_t;

   state_t state;
   state_t next_state;

   logic [LOCK_W-1:0]   lock_cnt;
   logic [RST_W-1:0]    rst_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [SETTLE_W-1:0] settle_cnt;

   // State register; reset lands in WAIT_LOCK with the datapath held in reset.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_LOCK;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; lock loss has top priority, and err beats settle completion.
   always_comb begin
      next_state = state;
      case (state)
         WAIT_LOCK: begin
            if (all_lock && (lock_cnt == LOCK_LAST)) begin
               next_state = DP_RST;
            end
         end
         DP_RST: begin
            if (!all_lock) begin
               next_state = WAIT_LOCK;
            end else if (rst_cnt == RST_LAST) begin
               next_state = ALIGN;
            end
         end
         ALIGN: begin
            if (!all_lock) begin
               next_state = WAIT_LOCK;
            end else if (err || (tmo_cnt == TMO_LAST)) begin
               next_state = RETRY;
            end else if (good && (settle_cnt == SETTLE_LAST)) begin
               next_state = READY;
            end
         end
         RETRY: begin
            if (retry_cnt == RETRY_MAX) begin
               next_state = FAIL;
            end else begin
               next_state = DP_RST;
            end
         end
         READY: begin
            if (!all_lock) begin
               next_state = WAIT_LOCK;
            end else if (err) begin
               next_state = RETRY;
            end
         end
         FAIL: begin
            next_state = FAIL;
         end
         default: begin
            next_state = WAIT_LOCK;
         end
      endcase
   end

   // Phase counters: all clear on any state change, and each runs only in its own state.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt   <= '0;
         rst_cnt    <= '0;
         tmo_cnt    <= '0;
         settle_cnt <= '0;
      end else if (next_state != state) begin
         lock_cnt   <= '0;
         rst_cnt    <= '0;
         tmo_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               lock_cnt <= all_lock ? lock_cnt + 1'b1 : '0;
            end
            DP_RST: begin
               rst_cnt <= rst_cnt + 1'b1;
            end
            ALIGN: begin
               tmo_cnt    <= tmo_cnt + 1'b1;
               settle_cnt <= (good && !err) ? settle_cnt + 1'b1 : '0;
            end
            default: begin
               lock_cnt <= lock_cnt;
            end
         endcase
      end
   end

   // Retry counter bumps only when a retry actually re-enters DP_RST; kept across lock loss.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         retry_cnt <= 2'd0;
      end else if ((state == RETRY) && (next_state == DP_RST)) begin
         retry_cnt <= retry_cnt + 2'd1;
      end
   end

   // Status outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         reset_datapath <= 1'b1;
         ready          <= 1'b0;
         fail           <= 1'b0;
      end else begin
         reset_datapath <= (next_state == WAIT_LOCK) || (next_state == DP_RST) ||
                           (next_state == FAIL);
         ready          <= (next_state == READY);
         fail           <= (next_state == FAIL);
      end
   end

   // DLL freeze path: request to uddcntln to ack, two registers, only honoured while READY.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         uddcntln     <= 1'b0;
         dll_hold_ack <= 1'b0;
      end else begin
         uddcntln     <= (state == READY) && dll_hold_req;
         dll_hold_ack <= (state == READY) && uddcntln;
      end
   end

endmodule
